// File: rtl/pipe_exec_ctrl_pkg.sv
// Shared definitions for the execution sequencer: FSM states, debug command codes
// and dump-length helpers.
package pipe_exec_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RUN,
        ST_STEP,
        ST_DPC,
        ST_DCYC,
        ST_RREQ,
        ST_RWAIT,
        ST_MREQ,
        ST_MWAIT,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        CMD_RUN   = 2'd0,
        CMD_STEP  = 2'd1,
        CMD_DUMP  = 2'd2,
        CMD_CLEAR = 2'd3
    } cmd_e;

    // PC and cycle count precede the register and memory words.
    localparam int DUMP_HDR_WORDS = 2;

    function automatic int dump_len(input int nb_reg, input int n_mem_words);
        return DUMP_HDR_WORDS + (1 << nb_reg) + n_mem_words;
    endfunction

endpackage

// File: rtl/pexc_cycle_ctr.sv
// Saturating executed-cycle counter with synchronous clear and count enable.
module pexc_cycle_ctr #(
    parameter int NB = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          enable,
    output logic [NB-1:0] count
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != {NB{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_exec_ctrl.sv
// Execution sequencer: RUN/STEP gating of pipeline and data memory, cycle counting and
// a handshaked state dump. Optional RUN watchdog enabled by defining PIPE_EXEC_WDOG_EN.
module pipe_exec_ctrl
    import pipe_exec_ctrl_pkg::*;
#(
    parameter int NB_DATA     = 32,
    parameter int NB_REG      = 5,
    parameter int NB_ADDR     = 10,
    parameter int N_MEM_WORDS = 32,
    parameter int MAX_CYCLES  = 1024
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_cmd_valid,
    input  logic [1:0]         i_cmd,
    output logic               o_cmd_ready,
    input  logic               i_halt,
    input  logic [NB_ADDR-1:0] i_pc,
    input  logic [NB_DATA-1:0] i_reg_data,
    input  logic [NB_DATA-1:0] i_mem_data,
    output logic               o_enable_pipe,
    output logic               o_enable_mem,
    output logic               o_rd_reg,
    output logic [NB_REG-1:0]  o_addr_reg,
    output logic               o_rd_mem,
    output logic [NB_ADDR-1:0] o_addr_mem,
    output logic [NB_ADDR-1:0] o_cycles,
    output logic               o_dump_valid,
    output logic [NB_DATA-1:0] o_dump_data,
    input  logic               i_dump_ready,
    output logic               o_halted
);

    localparam int N_REGS = 2 ** NB_REG;

    state_e               state;
    state_e               state_next;
    logic                 halted;
    logic                 timeout;
    logic                 held;
    logic [NB_REG-1:0]    reg_idx;
    logic [NB_ADDR-1:0]   mem_idx;
    logic [NB_DATA-1:0]   dump_word;
    logic                 cmd_fire;
    logic                 cnt_clear;
    logic                 exec;
    logic                 last_reg;
    logic                 last_mem;
    logic                 wdog_hit;

    assign cmd_fire  = i_cmd_valid && (state == ST_IDLE);
    assign cnt_clear = cmd_fire && (cmd_e'(i_cmd) == CMD_CLEAR);
    assign exec      = (state == ST_RUN) || (state == ST_STEP);
    assign last_reg  = (reg_idx == NB_REG'(N_REGS - 1));
    assign last_mem  = (mem_idx == NB_ADDR'(N_MEM_WORDS - 1));

    assign o_addr_reg = reg_idx;
    assign o_addr_mem = mem_idx;
    assign o_halted   = halted;

`ifdef PIPE_EXEC_WDOG_EN
    logic [31:0] run_cnt;

    always_ff @(posedge i_clock) begin
        if (!i_reset || (state != ST_RUN)) begin
            run_cnt <= '0;
        end else begin
            run_cnt <= run_cnt + 1'b1;
        end
    end

    assign wdog_hit = (state == ST_RUN) && (run_cnt == 32'(MAX_CYCLES - 1));
`else
    logic unused_max_cycles;

    assign wdog_hit          = 1'b0;
    assign unused_max_cycles = (MAX_CYCLES > 0);
`endif

    pexc_cycle_ctr #(
        .NB (NB_ADDR)
    ) u_cycle_ctr (
        .clk    (i_clock),
        .rst_n  (i_reset),
        .clear  (cnt_clear),
        .enable (exec),
        .count  (o_cycles)
    );

    // NOTE: reset is sampled on the clock edge only; it is not in the sensitivity list.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output and next-state value gets a default first, so no path infers a latch.
    always_comb begin
        state_next    = state;
        o_cmd_ready   = 1'b0;
        o_enable_pipe = 1'b0;
        o_enable_mem  = 1'b0;
        o_rd_reg      = 1'b0;
        o_rd_mem      = 1'b0;
        o_dump_valid  = 1'b0;
        o_dump_data   = '0;
        case (state)
            ST_IDLE: begin
                o_cmd_ready = 1'b1;
                if (i_cmd_valid) begin
                    case (cmd_e'(i_cmd))
                        CMD_RUN:   if (!halted) state_next = ST_RUN;
                        CMD_STEP:  if (!halted) state_next = ST_STEP;
                        CMD_DUMP:  state_next = ST_DPC;
                        default:   state_next = ST_IDLE;
                    endcase
                end
            end
            ST_RUN: begin
                o_enable_pipe = 1'b1;
                o_enable_mem  = 1'b1;
                if (i_halt || wdog_hit) state_next = ST_DPC;
            end
            ST_STEP: begin
                o_enable_pipe = 1'b1;
                o_enable_mem  = 1'b1;
                state_next    = ST_DPC;
            end
            ST_DPC: begin
                o_dump_valid = 1'b1;
                o_dump_data  = {{(NB_DATA - NB_ADDR){1'b0}}, i_pc};
                if (i_dump_ready) state_next = ST_DCYC;
            end
            ST_DCYC: begin
                o_dump_valid = 1'b1;
                o_dump_data  = {timeout, {(NB_DATA - NB_ADDR - 1){1'b0}}, o_cycles};
                if (i_dump_ready) state_next = ST_RREQ;
            end
            ST_RREQ: begin
                o_rd_reg   = 1'b1;
                state_next = ST_RWAIT;
            end
            ST_RWAIT: begin
                o_dump_valid = 1'b1;
                o_dump_data  = held ? dump_word : i_reg_data;
                if (i_dump_ready) state_next = last_reg ? ST_MREQ : ST_RREQ;
            end
            ST_MREQ: begin
                o_enable_mem = 1'b1;
                o_rd_mem     = 1'b1;
                state_next   = ST_MWAIT;
            end
            ST_MWAIT: begin
                o_enable_mem = 1'b1;
                o_dump_valid = 1'b1;
                o_dump_data  = held ? dump_word : i_mem_data;
                if (i_dump_ready) state_next = last_mem ? ST_DONE : ST_MREQ;
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Read data is shown live in the first WAIT cycle and frozen in dump_word while stalled.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            halted    <= 1'b0;
            timeout   <= 1'b0;
            held      <= 1'b0;
            reg_idx   <= '0;
            mem_idx   <= '0;
            dump_word <= '0;
        end else begin
            if (cnt_clear) begin
                halted  <= 1'b0;
                timeout <= 1'b0;
            end else if (exec && (i_halt || wdog_hit)) begin
                halted  <= 1'b1;
                timeout <= wdog_hit && !i_halt;
            end

            if ((state == ST_RWAIT) && i_dump_ready) begin
                reg_idx <= reg_idx + 1'b1;
            end
            if ((state == ST_MWAIT) && i_dump_ready) begin
                mem_idx <= last_mem ? '0 : mem_idx + 1'b1;
            end

            if ((state == ST_RWAIT) || (state == ST_MWAIT)) begin
                if (!held) dump_word <= o_dump_data;
                held <= !i_dump_ready;
            end else begin
                held <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pipe_exec_ctrl.sv
// Directed testbench for pipe_exec_ctrl with 1-cycle-latency register/memory models.
// Runs the watchdog scenario instead of saturation when PIPE_EXEC_WDOG_EN is defined.
module tb_pipe_exec_ctrl;

    localparam int NB_DATA    = 32;
    localparam int NB_REG     = 5;
    localparam int NB_ADDR    = 10;
    localparam int N_MEM      = 32;
    localparam int DUMP_WORDS = 66;
`ifdef PIPE_EXEC_WDOG_EN
    localparam int MAXC = 16;
`else
    localparam int MAXC = 1024;
`endif

    localparam logic [1:0] C_RUN   = 2'd0;
    localparam logic [1:0] C_STEP  = 2'd1;
    localparam logic [1:0] C_DUMP  = 2'd2;
    localparam logic [1:0] C_CLEAR = 2'd3;

    logic               clk = 1'b0;
    logic               i_reset = 1'b0;
    logic               i_cmd_valid = 1'b0;
    logic [1:0]         i_cmd = 2'd0;
    logic               o_cmd_ready;
    logic               i_halt = 1'b0;
    logic [NB_ADDR-1:0] i_pc = 10'h155;
    logic [NB_DATA-1:0] reg_q = '0;
    logic [NB_DATA-1:0] mem_q = '0;
    logic               o_enable_pipe;
    logic               o_enable_mem;
    logic               o_rd_reg;
    logic [NB_REG-1:0]  o_addr_reg;
    logic               o_rd_mem;
    logic [NB_ADDR-1:0] o_addr_mem;
    logic [NB_ADDR-1:0] o_cycles;
    logic               o_dump_valid;
    logic [NB_DATA-1:0] o_dump_data;
    logic               i_dump_ready = 1'b1;
    logic               o_halted;

    int checks = 0;
    int errors = 0;
    int en_cnt = 0;
    logic [31:0] words[$];

    always #5 clk = ~clk;

    pipe_exec_ctrl #(
        .NB_DATA     (NB_DATA),
        .NB_REG      (NB_REG),
        .NB_ADDR     (NB_ADDR),
        .N_MEM_WORDS (N_MEM),
        .MAX_CYCLES  (MAXC)
    ) dut (
        .i_clock       (clk),
        .i_reset       (i_reset),
        .i_cmd_valid   (i_cmd_valid),
        .i_cmd         (i_cmd),
        .o_cmd_ready   (o_cmd_ready),
        .i_halt        (i_halt),
        .i_pc          (i_pc),
        .i_reg_data    (reg_q),
        .i_mem_data    (mem_q),
        .o_enable_pipe (o_enable_pipe),
        .o_enable_mem  (o_enable_mem),
        .o_rd_reg      (o_rd_reg),
        .o_addr_reg    (o_addr_reg),
        .o_rd_mem      (o_rd_mem),
        .o_addr_mem    (o_addr_mem),
        .o_cycles      (o_cycles),
        .o_dump_valid  (o_dump_valid),
        .o_dump_data   (o_dump_data),
        .i_dump_ready  (i_dump_ready),
        .o_halted      (o_halted)
    );

    function automatic logic [31:0] reg_val(input logic [NB_REG-1:0] a);
        return 32'hA5A5_0000 + {27'd0, a};
    endfunction

    function automatic logic [31:0] mem_val(input logic [NB_ADDR-1:0] a);
        return 32'h3C3C_0000 + {22'd0, a};
    endfunction

    always @(posedge clk) begin
        if (o_rd_reg) reg_q <= reg_val(o_addr_reg);
        if (o_rd_mem) mem_q <= mem_val(o_addr_mem);
        if (o_enable_pipe) en_cnt <= en_cnt + 1;
    end

    // Number of register/memory words in the captured dump that differ from the models.
    function automatic int body_errors();
        int bad = 0;
        if (words.size() != DUMP_WORDS) return DUMP_WORDS;
        for (int i = 0; i < 32; i++)
            if (words[2 + i] !== reg_val(NB_REG'(i))) bad++;
        for (int i = 0; i < N_MEM; i++)
            if (words[34 + i] !== mem_val(NB_ADDR'(i))) bad++;
        return bad;
    endfunction

    task automatic cmd(input logic [1:0] c);
        i_cmd_valid = 1'b1;
        i_cmd       = c;
        @(negedge clk);
        i_cmd_valid = 1'b0;
        i_cmd       = 2'd0;
    endtask

    task automatic run_halt(input int n);
        cmd(C_RUN);
        repeat (n - 1) @(negedge clk);
        i_halt = 1'b1;
        @(negedge clk);
        i_halt = 1'b0;
    endtask

    task automatic collect(input int stall_idx, input int stall_len, input int budget);
        int stalls = 0;
        bit done = 1'b0;
        logic [31:0] held_word = '0;
        words.delete();
        i_dump_ready = 1'b1;
        for (int i = 0; i < budget && !done; i++) begin
            if (o_cmd_ready) begin
                done = 1'b1;
            end else begin
                if (o_dump_valid && words.size() == stall_idx && stalls < stall_len) begin
                    checks++;
                    if (o_addr_reg !== NB_REG'(stall_idx - 2)) begin
                        errors++;
                        $display("FAIL stall_addr_reg: got %0d want %0d", o_addr_reg, stall_idx - 2);
                    end
                    if (stalls == 0) begin
                        held_word = o_dump_data;
                    end else begin
                        checks++;
                        if (o_dump_data !== held_word) begin
                            errors++;
                            $display("FAIL stall_data: got %08h want %08h", o_dump_data, held_word);
                        end
                    end
                    stalls++;
                    i_dump_ready = 1'b0;
                end else begin
                    if (o_dump_valid) begin
                        if (stalls > 0 && words.size() == stall_idx) begin
                            checks++;
                            if (o_dump_data !== held_word) begin
                                errors++;
                                $display("FAIL stall_release_data: got %08h want %08h", o_dump_data, held_word);
                            end
                        end
                        words.push_back(o_dump_data);
                    end
                    i_dump_ready = 1'b1;
                end
                @(negedge clk);
            end
        end
        i_dump_ready = 1'b1;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL dump_timeout: got busy after %0d cycles want idle", budget);
        end
    endtask

    task automatic check_dump(input string name, input logic [31:0] pc_w, input logic [31:0] cyc_w);
        checks++;
        if (words.size() != DUMP_WORDS) begin
            errors++;
            $display("FAIL %s_len: got %0d want %0d", name, words.size(), DUMP_WORDS);
        end
        checks++;
        if (words[0] !== pc_w) begin
            errors++;
            $display("FAIL %s_pc: got %08h want %08h", name, words[0], pc_w);
        end
        checks++;
        if (words[1] !== cyc_w) begin
            errors++;
            $display("FAIL %s_cycles: got %08h want %08h", name, words[1], cyc_w);
        end
        checks++;
        if (body_errors() !== 0) begin
            errors++;
            $display("FAIL %s_body: got %0d bad words want 0", name, body_errors());
        end
    endtask

    task automatic test_reset();
        i_reset = 1'b0;
        repeat (2) @(negedge clk);
        i_reset = 1'b1;
        checks++;
        if (o_cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_cmd_ready: got %0b want 1", o_cmd_ready);
        end
        checks++;
        if ({o_enable_pipe, o_enable_mem, o_rd_reg, o_rd_mem, o_dump_valid, o_halted} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %06b want 000000",
                     {o_enable_pipe, o_enable_mem, o_rd_reg, o_rd_mem, o_dump_valid, o_halted});
        end
        checks++;
        if ({o_cycles, o_addr_reg, o_addr_mem, o_dump_data} !== '0) begin
            errors++;
            $display("FAIL reset_values: got cyc=%0d areg=%0d amem=%0d data=%08h want 0",
                     o_cycles, o_addr_reg, o_addr_mem, o_dump_data);
        end
    endtask

    task automatic test_reset_mid_run();
        cmd(C_RUN);
        repeat (3) @(negedge clk);
        checks++;
        if (o_enable_pipe !== 1'b1 || o_cycles !== 10'd3) begin
            errors++;
            $display("FAIL run_before_reset: got en=%0b cyc=%0d want en=1 cyc=3", o_enable_pipe, o_cycles);
        end
        i_reset = 1'b0;
        @(negedge clk);
        i_reset = 1'b1;
        checks++;
        if (o_enable_pipe !== 1'b0 || o_cycles !== 10'd0 || o_cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_run_reset: got en=%0b cyc=%0d rdy=%0b want en=0 cyc=0 rdy=1",
                     o_enable_pipe, o_cycles, o_cmd_ready);
        end
        i_halt = 1'b1;
        repeat (3) @(negedge clk);
        i_halt = 1'b0;
        checks++;
        if (o_halted !== 1'b0 || o_cmd_ready !== 1'b1 || o_enable_pipe !== 1'b0) begin
            errors++;
            $display("FAIL idle_halt_ignored: got halted=%0b rdy=%0b en=%0b want 0 1 0",
                     o_halted, o_cmd_ready, o_enable_pipe);
        end
    endtask

    task automatic test_run_halt();
        int e0 = en_cnt;
        run_halt(7);
        checks++;
        if (o_cycles !== 10'd7 || o_halted !== 1'b1) begin
            errors++;
            $display("FAIL halt_state: got cyc=%0d halted=%0b want cyc=7 halted=1", o_cycles, o_halted);
        end
        checks++;
        if (o_enable_pipe !== 1'b0 || o_dump_valid !== 1'b1 || en_cnt - e0 != 7) begin
            errors++;
            $display("FAIL halt_enables: got en=%0b valid=%0b en_cycles=%0d want 0 1 7",
                     o_enable_pipe, o_dump_valid, en_cnt - e0);
        end
        collect(-1, 0, 400);
        check_dump("run_dump", 32'h155, 32'd7);
    endtask

    task automatic test_step();
        cmd(C_CLEAR);
        checks++;
        if (o_cycles !== 10'd0 || o_halted !== 1'b0) begin
            errors++;
            $display("FAIL clear_before_step: got cyc=%0d halted=%0b want 0 0", o_cycles, o_halted);
        end
        for (int k = 1; k <= 3; k++) begin
            int e0 = en_cnt;
            cmd(C_STEP);
            collect(-1, 0, 400);
            checks++;
            if (o_cycles !== NB_ADDR'(k) || en_cnt - e0 != 1) begin
                errors++;
                $display("FAIL step_%0d: got cyc=%0d en_cycles=%0d want cyc=%0d en_cycles=1",
                         k, o_cycles, en_cnt - e0, k);
            end
            check_dump("step_dump", 32'h155, 32'(k));
        end
    endtask

    task automatic test_backpressure();
        cmd(C_DUMP);
        collect(6, 5, 400);
        check_dump("bp_dump", 32'h155, 32'd3);
    endtask

    task automatic test_halted_ignored();
        run_halt(2);
        collect(-1, 0, 400);
        checks++;
        if (o_halted !== 1'b1 || o_cycles !== 10'd5) begin
            errors++;
            $display("FAIL halted_after_run: got halted=%0b cyc=%0d want 1 5", o_halted, o_cycles);
        end
        cmd(C_RUN);
        checks++;
        if (o_cmd_ready !== 1'b1 || o_enable_pipe !== 1'b0) begin
            errors++;
            $display("FAIL run_while_halted: got rdy=%0b en=%0b want 1 0", o_cmd_ready, o_enable_pipe);
        end
        cmd(C_STEP);
        checks++;
        if (o_cmd_ready !== 1'b1 || o_enable_pipe !== 1'b0 || o_cycles !== 10'd5) begin
            errors++;
            $display("FAIL step_while_halted: got rdy=%0b en=%0b cyc=%0d want 1 0 5",
                     o_cmd_ready, o_enable_pipe, o_cycles);
        end
        cmd(C_CLEAR);
        checks++;
        if (o_cycles !== 10'd0 || o_halted !== 1'b0) begin
            errors++;
            $display("FAIL clear: got cyc=%0d halted=%0b want 0 0", o_cycles, o_halted);
        end
        run_halt(3);
        checks++;
        if (o_cycles !== 10'd3 || o_halted !== 1'b1) begin
            errors++;
            $display("FAIL run_after_clear: got cyc=%0d halted=%0b want 3 1", o_cycles, o_halted);
        end
        collect(-1, 0, 400);
        check_dump("clear_dump", 32'h155, 32'd3);
    endtask

`ifdef PIPE_EXEC_WDOG_EN
    task automatic test_watchdog();
        int e0;
        cmd(C_CLEAR);
        e0 = en_cnt;
        cmd(C_RUN);
        for (int i = 0; i < 40 && !o_dump_valid; i++) @(negedge clk);
        checks++;
        if (o_dump_valid !== 1'b1 || o_cycles !== 10'd16 || o_halted !== 1'b1 || en_cnt - e0 != 16) begin
            errors++;
            $display("FAIL watchdog: got valid=%0b cyc=%0d halted=%0b en_cycles=%0d want 1 16 1 16",
                     o_dump_valid, o_cycles, o_halted, en_cnt - e0);
        end
        collect(-1, 0, 400);
        check_dump("wdog_dump", 32'h155, 32'h8000_0010);
    endtask
`else
    task automatic test_saturate();
        cmd(C_CLEAR);
        cmd(C_RUN);
        repeat (1029) @(negedge clk);
        checks++;
        if (o_cycles !== 10'h3FF || o_enable_pipe !== 1'b1) begin
            errors++;
            $display("FAIL saturate: got cyc=%0h en=%0b want 3ff 1", o_cycles, o_enable_pipe);
        end
        i_halt = 1'b1;
        @(negedge clk);
        i_halt = 1'b0;
        checks++;
        if (o_cycles !== 10'h3FF || o_halted !== 1'b1) begin
            errors++;
            $display("FAIL saturate_halt: got cyc=%0h halted=%0b want 3ff 1", o_cycles, o_halted);
        end
        collect(-1, 0, 400);
        check_dump("sat_dump", 32'h155, 32'h3FF);
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_reset_mid_run();
        test_run_halt();
        test_step();
        test_backpressure();
        test_halted_ignored();
`ifdef PIPE_EXEC_WDOG_EN
        test_watchdog();
`else
        test_saturate();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
